// File: rtl/md_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : md_step_sequencer
//  Description : Timestep controller for the range-limited force core.
//                Issues the force-core start burst, collects per-cell
//                read-complete status into a sticky mask, waits for the
//                filter buffers and force outputs to stay quiet, then hands
//                off to motion update.  Repeats for num_steps timesteps.
//  Revision    : 1.0  initial release
// ============================================================================
module md_step_sequencer #(
   parameter int NUM_CELLS    = 64,
   parameter int STEP_WIDTH   = 16,
   parameter int START_CYCLES = 4,
   parameter int DRAIN_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  go,
   input  logic [STEP_WIDTH-1:0] num_steps,
   input  logic [NUM_CELLS-1:0]  reading_done,
   input  logic [NUM_CELLS-1:0]  filter_buffer_empty,
   input  logic [NUM_CELLS-1:0]  force_valid,
   input  logic                  mu_done,
   output logic                  start,
   output logic                  mu_start,
   output logic                  busy,
   output logic [STEP_WIDTH-1:0] step_count,
   output logic                  all_done
);

   // Counter widths: the start counter only has to reach START_CYCLES-1,
   // the quiet counter is allowed to reach DRAIN_CYCLES on the exit edge.
   localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam int QW  = $clog2(DRAIN_CYCLES + 1);

   localparam logic [SCW-1:0] C_START_LAST = SCW'(START_CYCLES - 1);
   localparam logic [QW-1:0]  C_QUIET_LAST = QW'(DRAIN_CYCLES - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_FORCE = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_MU    = 3'd4;
   localparam logic [2:0] S_NEXT  = 3'd5;

   logic [2:0]            r_state;
   logic [NUM_CELLS-1:0]  r_mask;
   logic [QW-1:0]         r_quiet;
   logic [SCW-1:0]        r_start_cnt;
   logic [STEP_WIDTH-1:0] r_num_steps;

   logic                  w_quiet;
   logic                  w_mask_full;
   logic [STEP_WIDTH-1:0] w_step_next;

   // Status decode: a cycle is quiet only if every buffer is empty and no
   // cell presents a valid force.
   always_comb begin
      w_quiet     = (&filter_buffer_empty) && !(|force_valid);
      w_mask_full = &r_mask;
      w_step_next = step_count + STEP_WIDTH'(1);
   end

   // Sequencer state, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_mask      <= '0;
         r_quiet     <= '0;
         r_start_cnt <= '0;
         r_num_steps <= '0;
         start       <= 1'b0;
         mu_start    <= 1'b0;
         busy        <= 1'b0;
         all_done    <= 1'b0;
         step_count  <= '0;
      end else begin
         // Pulses default low; each state raises them for a single cycle.
         mu_start <= 1'b0;
         all_done <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (go) begin
                  if (num_steps != '0) begin
                     r_num_steps <= num_steps;
                     step_count  <= '0;
                     r_mask      <= '0;
                     r_start_cnt <= '0;
                     start       <= 1'b1;
                     busy        <= 1'b1;
                     r_state     <= S_START;
                  end else begin
                     // Empty run: report completion without touching the core.
                     all_done <= 1'b1;
                  end
               end
            end

            S_START: begin
               r_mask <= r_mask | reading_done;
               if (r_start_cnt == C_START_LAST) begin
                  start   <= 1'b0;
                  r_state <= S_FORCE;
               end else begin
                  r_start_cnt <= r_start_cnt + SCW'(1);
               end
            end

            S_FORCE: begin
               r_mask <= r_mask | reading_done;
               // Decision uses the registered mask, so exit lags completion by one cycle.
               if (w_mask_full) begin
                  r_quiet <= '0;
                  r_state <= S_DRAIN;
               end
            end

            S_DRAIN: begin
               if (!w_quiet) begin
                  r_quiet <= '0;
               end else if (r_quiet == C_QUIET_LAST) begin
                  // This cycle completes the required quiet run.
                  r_quiet  <= r_quiet + QW'(1);
                  mu_start <= 1'b1;
                  r_state  <= S_MU;
               end else begin
                  r_quiet <= r_quiet + QW'(1);
               end
            end

            S_MU: begin
               // mu_start is still high in the first MU cycle; mu_done is ignored there.
               if (mu_done && !mu_start) begin
                  step_count <= w_step_next;
                  all_done   <= (w_step_next == r_num_steps);
                  r_state    <= S_NEXT;
               end
            end

            S_NEXT: begin
               if (step_count == r_num_steps) begin
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_mask      <= '0;
                  r_start_cnt <= '0;
                  start       <= 1'b1;
                  r_state     <= S_START;
               end
            end

            default: begin
               start   <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_md_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_step_sequencer
//  Description : Self-checking bench for md_step_sequencer: directed vector
//                table, hand-written corner sequences and randomized runs
//                checked against an event-timeline reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_md_step_sequencer;

   localparam int NC   = 64;
   localparam int SW   = 16;
   localparam int MAXC = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          go;
   logic [SW-1:0] num_steps;
   logic [NC-1:0] reading_done;
   logic [NC-1:0] filter_buffer_empty;
   logic [NC-1:0] force_valid;
   logic          mu_done;
   logic          start;
   logic          mu_start;
   logic          busy;
   logic [SW-1:0] step_count;
   logic          all_done;

   md_step_sequencer #(
      .NUM_CELLS    (NC),
      .STEP_WIDTH   (SW),
      .START_CYCLES (4),
      .DRAIN_CYCLES (8)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .go                  (go),
      .num_steps           (num_steps),
      .reading_done        (reading_done),
      .filter_buffer_empty (filter_buffer_empty),
      .force_valid         (force_valid),
      .mu_done             (mu_done),
      .start               (start),
      .mu_start            (mu_start),
      .busy                (busy),
      .step_count          (step_count),
      .all_done            (all_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Per-cycle stimulus and expected outputs
   logic          go_a  [MAXC];
   logic [SW-1:0] ns_a  [MAXC];
   logic [NC-1:0] rd_a  [MAXC];
   logic [NC-1:0] fbe_a [MAXC];
   logic [NC-1:0] fv_a  [MAXC];
   logic          mud_a [MAXC];
   logic          dist_a[MAXC];
   logic          e_st  [MAXC];
   logic          e_mu  [MAXC];
   logic          e_bz  [MAXC];
   logic          e_dn  [MAXC];
   logic [SW-1:0] e_sc  [MAXC];
   logic [SW-1:0] model_step;

   typedef struct {
      int stagger;
      int rd_at;
      int dist_at;
      int dist_kind;
      int mud_early;
      int mud_at;
      int exp_mu;
      int exp_done;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] obs();
      return {12'b0, start, mu_start, busy, all_done, step_count};
   endfunction

   task automatic drive_idle();
      go                  = 1'b0;
      num_steps           = '0;
      reading_done        = '0;
      filter_buffer_empty = '1;
      force_valid         = '0;
      mu_done             = 1'b0;
   endtask

   task automatic clear_stim();
      for (int k = 0; k < MAXC; k++) begin
         go_a[k]   = 1'b0;
         ns_a[k]   = '0;
         rd_a[k]   = '0;
         fbe_a[k]  = '1;
         fv_a[k]   = '0;
         mud_a[k]  = 1'b0;
         dist_a[k] = 1'b0;
         e_st[k]   = 1'b0;
         e_mu[k]   = 1'b0;
         e_bz[k]   = 1'b0;
         e_dn[k]   = 1'b0;
         e_sc[k]   = model_step;
      end
   endtask

   task automatic apply(input int k);
      go                  = go_a[k];
      num_steps           = ns_a[k];
      reading_done        = rd_a[k];
      filter_buffer_empty = fbe_a[k];
      force_valid         = fv_a[k];
      mu_done             = mud_a[k];
   endtask

   task automatic disturb(input int t);
      int c;
      c = $urandom_range(0, NC-1);
      if ($urandom_range(0, 1) == 0) fv_a[t][c] = 1'b1;
      else                           fbe_a[t][c] = 1'b0;
   endtask

   // Reference timeline for one run of n steps, go presented in cycle 2.
   // Cycle k inputs are sampled at the end of cycle k; e_*[k] are outputs seen in cycle k.
   task automatic build_random(input int n, output int len);
      int s, f, m, d, u0, x, t, rmax, nd, prev_d;
      bit hit;
      clear_stim();
      for (int k = 0; k < MAXC; k++) ns_a[k] = SW'($urandom);
      go_a[2] = 1'b1;
      ns_a[2] = SW'(n);
      s = 3;
      prev_d = 0;
      x = 0;
      for (int j = 0; j < n; j++) begin
         // reading_done outside START/FORCE must not reach the mask
         for (int c = 0; c < NC; c++)
            if ($urandom_range(0, 7) == 0) begin
               t = $urandom_range(prev_d, s - 1);
               rd_a[t][c] = 1'b1;
            end
         rmax = $urandom_range(0, 30);
         m = 0;
         for (int c = 0; c < NC; c++) begin
            t = s + $urandom_range(0, rmax);
            rd_a[t][c] = 1'b1;
            if (t + 1 > m) m = t + 1;
         end
         f = s + 4;
         d = ((m > f) ? m : f) + 1;
         nd = $urandom_range(0, 2);
         for (int i = 0; i < nd; i++) disturb($urandom_range(s, d - 1));
         nd = $urandom_range(0, 3);
         for (int i = 0; i < nd; i++) begin
            t = $urandom_range(d, d + 20);
            disturb(t);
            dist_a[t] = 1'b1;
         end
         // mu_start: first cycle with 8 undisturbed DRAIN cycles just before it
         u0 = d + 8;
         do begin
            hit = 1'b0;
            for (int k = u0 - 8; k < u0; k++) if (dist_a[k]) hit = 1'b1;
            if (hit) u0++;
         end while (hit);
         if ($urandom_range(0, 1) == 1) mud_a[$urandom_range(s, u0)] = 1'b1;
         x = u0 + $urandom_range(1, 6);
         mud_a[x] = 1'b1;
         for (int k = s; k <= x + 1; k++) begin
            e_bz[k] = 1'b1;
            e_sc[k] = SW'(j);
         end
         for (int k = s; k < s + 4; k++) e_st[k] = 1'b1;
         e_mu[u0]  = 1'b1;
         e_sc[x+1] = SW'(j + 1);
         e_dn[x+1] = (j + 1 == n);
         prev_d = d;
         s = x + 2;
      end
      for (int k = s; k < s + 4; k++) e_sc[k] = SW'(n);
      for (int k = 3; k <= x + 1; k++) if ($urandom_range(0, 15) == 0) go_a[k] = 1'b1;
      len = s + 4;
   endtask

   task automatic play(input int len, input int n, input int run);
      int nst, nmu, ndn;
      logic prev;
      nst = 0; nmu = 0; ndn = 0; prev = 1'b0;
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         check($sformatf("run%0d_cyc%0d", run, k), obs(),
               {12'b0, e_st[k], e_mu[k], e_bz[k], e_dn[k], e_sc[k]});
         if (start && !prev) nst++;
         prev = start;
         if (mu_start) nmu++;
         if (all_done) ndn++;
         apply(k);
      end
      check($sformatf("run%0d_start_bursts", run), nst, n);
      check($sformatf("run%0d_mu_pulses", run), nmu, n);
      check($sformatf("run%0d_all_done", run), ndn, 1);
   endtask

   task automatic run_row(input vec_t v, input int idx);
      int g, len, mu_at, done_at, nst, nmu, sc_done;
      g = 2;
      clear_stim();
      go_a[g] = 1'b1;
      ns_a[g] = SW'(1);
      for (int c = 0; c < NC; c++)
         if (v.stagger != 0 && c != NC - 1) rd_a[g + 1 + (c % 40)][c] = 1'b1;
         else                               rd_a[g + v.rd_at][c] = 1'b1;
      if (v.dist_at >= 0) begin
         if (v.dist_kind == 0) fv_a[g + v.dist_at][5]   = 1'b1;
         else                  fbe_a[g + v.dist_at][17] = 1'b0;
      end
      if (v.mud_early != 0) mud_a[g + v.exp_mu] = 1'b1;
      mud_a[g + v.mud_at] = 1'b1;
      len = g + v.exp_done + 4;
      mu_at = -1; done_at = -1; nst = 0; nmu = 0; sc_done = -1;
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         if (start) nst++;
         if (mu_start) begin
            nmu++;
            if (mu_at < 0) mu_at = k - g;
         end
         if (all_done && done_at < 0) begin
            done_at = k - g;
            sc_done = int'(step_count);
         end
         apply(k);
      end
      check($sformatf("vec%0d_mu_start_at", idx), mu_at, v.exp_mu);
      check($sformatf("vec%0d_mu_pulses", idx), nmu, 1);
      check($sformatf("vec%0d_all_done_at", idx), done_at, v.exp_done);
      check($sformatf("vec%0d_start_cycles", idx), nst, 4);
      check($sformatf("vec%0d_step_count", idx), sc_done, 1);
      check($sformatf("vec%0d_busy_after", idx), {31'b0, busy}, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int len, n, t, ns0;
      rst = 1'b0;
      drive_idle();
      model_step = '0;

      // Reset values
      repeat (3) @(negedge clk);
      check("reset_outputs", obs(), 0);
      rst = 1'b1;
      @(negedge clk);
      check("idle_after_reset", obs(), 0);

      // Directed vectors, times relative to the cycle go is presented
      vecs[0] = '{0, 21, -1, 0, 0, 36, 31, 37};
      vecs[1] = '{0,  1, -1, 0, 0, 19, 14, 20};
      vecs[2] = '{0, 21, 29, 0, 0, 43, 38, 44};
      vecs[3] = '{0, 21, 23, 1, 0, 37, 32, 38};
      vecs[4] = '{0,  4, -1, 0, 0, 15, 14, 16};
      vecs[5] = '{0,  5, -1, 0, 0, 17, 15, 18};
      vecs[6] = '{0, 21, 30, 1, 0, 40, 39, 41};
      vecs[7] = '{1, 50, -1, 0, 0, 65, 60, 66};
      vecs[8] = '{0,  1, -1, 0, 1, 15, 14, 16};
      for (int i = 0; i < 9; i++) run_row(vecs[i], i);

      // go with num_steps = 0
      drive_idle();
      @(negedge clk);
      go = 1'b1;
      num_steps = '0;
      @(negedge clk);
      go = 1'b0;
      check("zero_steps_pulse", {29'b0, start, busy, all_done}, 1);
      ns0 = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (start || busy || all_done) ns0++;
      end
      check("zero_steps_quiet", ns0, 0);

      // Reset during FORCE of step 2, then a clean restart
      reading_done = '1;
      go = 1'b1;
      num_steps = SW'(3);
      @(negedge clk);
      go = 1'b0;
      t = 0;
      while (!mu_start && t < 200) begin @(negedge clk); t++; end
      check("abort_mu_seen", {31'b0, t < 200}, 1);
      @(negedge clk);
      mu_done = 1'b1;
      @(negedge clk);
      mu_done = 1'b0;
      reading_done = '0;
      check("abort_step1_next", obs(), {12'b0, 4'b0010, 16'd1});
      repeat (8) @(negedge clk);
      check("abort_in_force", obs(), {12'b0, 4'b0010, 16'd1});
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("abort_reset_values", obs(), 0);
      @(negedge clk);
      check("abort_no_done", obs(), 0);
      reading_done = '1;
      go = 1'b1;
      num_steps = SW'(1);
      @(negedge clk);
      go = 1'b0;
      check("restart_clean", obs(), {12'b0, 4'b1010, 16'd0});
      t = 0;
      while (!mu_start && t < 200) begin @(negedge clk); t++; end
      check("restart_mu_seen", {31'b0, t < 200}, 1);
      @(negedge clk);
      mu_done = 1'b1;
      @(negedge clk);
      mu_done = 1'b0;
      check("restart_done", obs(), {12'b0, 4'b0011, 16'd1});
      @(negedge clk);
      check("restart_idle", obs(), {12'b0, 4'b0000, 16'd1});
      drive_idle();
      model_step = SW'(1);

      // Randomized runs against the timeline model
      for (int r = 0; r < 12; r++) begin
         n = (r == 0) ? 3 : $urandom_range(1, 4);
         build_random(n, len);
         play(len, n, r);
         model_step = SW'(n);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/md_step_sequencer.md
# md_step_sequencer

Timestep controller sitting directly upstream of the range-limited force core (RL_top). It issues the `start` request the core consumes and watches the per-cell `reading_done`, `filter_buffer_empty` and `force_valid` status the core produces. Once every cell has finished reading and drained, it hands off to the motion-update stage. It repeats this for a programmed number of timesteps.

## Interface
- `NUM_CELLS`, 64, number of cells / width of status vectors
- `STEP_WIDTH`, 16, width of timestep counter
- `START_CYCLES`, 4, cycles `start` is held high per timestep (≥1)
- `DRAIN_CYCLES`, 8, consecutive quiet cycles required before force phase is declared complete (≥1)
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `go`  in  1  run request; sampled only in IDLE
- `num_steps`  in  STEP_WIDTH  timesteps to run; latched when `go` is accepted
- `reading_done`  in  NUM_CELLS  per-cell read-complete status from force core
- `filter_buffer_empty`  in  NUM_CELLS  per-cell filter buffer empty
- `force_valid`  in  NUM_CELLS  per-cell force output valid
- `mu_done`  in  1  motion-update complete pulse
- `start`  out  1  force-core start
- `mu_start`  out  1  one-cycle motion-update start pulse
- `busy`  out  1  high in every state except IDLE
- `step_count`  out  STEP_WIDTH  completed timesteps in the current run
- `all_done`  out  1  one-cycle pulse when the run finishes

## Operation
- States: IDLE, START, FORCE, DRAIN, MU, NEXT.
- IDLE:
  - On `go`=1 with `num_steps`≠0: latch `num_steps`, clear `step_count`, go to START.
  - On `go`=1 with `num_steps`=0: pulse `all_done` next cycle and stay in IDLE; `start` is never asserted.
- START:
  - `start`=1 for exactly START_CYCLES cycles.
  - The sticky done mask (NUM_CELLS bits) is cleared on entry.
  - Go to FORCE after the last cycle.
- Sticky mask: in START and FORCE, each bit is set when its `reading_done` bit is 1. Bits are never cleared by an input deasserting.
- FORCE: when the mask is all ones, go to DRAIN. The mask is registered, so the transition occurs on the cycle after the mask completes.
- DRAIN:
  - A quiet counter is reset to 0 in any cycle where any `filter_buffer_empty` bit is 0 or any `force_valid` bit is 1; otherwise it increments.
  - When the counter reaches DRAIN_CYCLES, go to MU.
  - The counter is cleared on DRAIN entry.
- MU:
  - `mu_start`=1 on the first MU cycle only.
  - `mu_done` is ignored in that first cycle.
  - On a later `mu_done`=1, go to NEXT.
- NEXT (one cycle):
  - `step_count` increments.
  - If the new value equals the latched `num_steps`: `all_done` pulses in this cycle and the next state is IDLE.
  - Otherwise the next state is START.
- `go` outside IDLE is ignored; `num_steps` changes after latch are ignored.
- The counter and `step_count` arithmetic is unsigned. `step_count` cannot exceed the latched `num_steps`, so it never wraps.

## Timing
- Reset values (rst=0 at a clock edge): state IDLE, `start`=0, `mu_start`=0, `busy`=0, `all_done`=0, `step_count`=0, mask=0, quiet counter=0.
- Reset mid-operation aborts immediately to IDLE with the same values; no `all_done` is produced.
- All outputs are registered.
- `go` sampled high at edge t → `busy`=1 and `start`=1 from t+1 through t+START_CYCLES.
- Full mask registered at edge m → DRAIN from m+1.
- Fully quiet from DRAIN entry d → `mu_start`=1 at d+DRAIN_CYCLES.
- `mu_done` at edge u → NEXT at u+1 (`step_count` updated, `all_done` if last step) → START or IDLE at u+2.
- `busy` drops on the cycle IDLE is re-entered. `all_done` and the last `busy`=1 cycle coincide.
- `reading_done` arriving during START is captured; if all bits are already set, FORCE lasts one cycle.

## Test plan
- `num_steps`=1, all cells assert `reading_done` 20 cycles after `start`, buffers empty, `force_valid`=0, `mu_done` 5 cycles after `mu_start`:
  - `start` high exactly 4 cycles.
  - `mu_start` one pulse 8 cycles after DRAIN entry.
  - `all_done` one pulse, `step_count`=1.
  - `busy` low afterwards.
- `num_steps`=3:
  - Exactly 3 `start` bursts and 3 `mu_start` pulses.
  - `step_count` reads 1, 2, 3.
  - A single `all_done`.
- Cells assert `reading_done` in staggered single-cycle pulses (cell 63 last, at cycle 50):
  - DRAIN entered only after cell 63.
  - No early `mu_start`.
- During DRAIN, `force_valid[5]`=1 at quiet-count 6, then quiet:
  - The counter restarts.
  - `mu_start` occurs 8 quiet cycles after the disturbance.
- `go` with `num_steps`=0: `all_done` pulses once, `start` never asserts. `go` pulsed mid-run: no effect.
- Assert rst=0 during FORCE of step 2:
  - Next cycle all outputs are zero and the state is IDLE.
  - A subsequent `go` starts cleanly from `step_count`=0.
